// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - opcode and result-select encodings
//   - dec_t: decoded control word {legal, sel[1:0], sub}
//   - alu_decode(): opcode -> dec_t
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  localparam logic [1:0] SEL_AND   = 2'b00;
  localparam logic [1:0] SEL_OR    = 2'b01;
  localparam logic [1:0] SEL_ARITH = 2'b10;
  localparam logic [1:0] SEL_XOR   = 2'b11;

  typedef struct packed {
    logic       legal;
    logic [1:0] sel;   // {s1, s0}
    logic       sub;
  } dec_t;

  function automatic dec_t alu_decode(input logic [2:0] op);
    dec_t d;
    d.legal = 1'b1;
    d.sel   = SEL_AND;
    d.sub   = 1'b0;
    case (op)
      OP_AND: d.sel = SEL_AND;
      OP_OR:  d.sel = SEL_OR;
      OP_ADD: d.sel = SEL_ARITH;
      OP_XOR: d.sel = SEL_XOR;
      OP_SUB: begin
        d.sel = SEL_ARITH;
        d.sub = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: generic 2-entry skid register (main + skid).
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     i_valid/o_ready     upstream handshake (o_ready = !skid_valid, registered)
//     i_data [W-1:0]      upstream payload
//     o_valid/i_ready     downstream handshake
//     o_data [W-1:0]      downstream payload, driven straight from main
//   Ops leave in arrival order; main and its data hold until drained.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;
  logic         w_drain;
  logic         w_push;

  assign w_drain = r_main_valid && i_ready;
  // Upstream is only allowed in while skid is empty.
  assign w_push  = i_valid && !r_skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (r_skid_valid) begin
      // Skid full implies main full; refill main from skid on drain.
      if (w_drain) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_main_valid || w_drain) begin
        r_main_data  <= i_data;
        r_main_valid <= 1'b1;
      end else begin
        r_skid_data  <= i_data;
        r_skid_valid <= 1'b1;
      end
    end else if (w_drain) begin
      r_main_valid <= 1'b0;
    end
  end

  assign o_ready = !r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage in front of the ALU result mux.
//   Decodes opcode into {s1,s0} and sub, forwards {a,b,s1,s0,sub} through
//   a 2-entry skid buffer; illegal opcodes are consumed and flagged.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     in_valid/in_ready            request handshake
//     in_op, in_a, in_b            opcode and operands
//     out_valid/out_ready          issue handshake to datapath
//     out_a, out_b                 registered operands (b not inverted)
//     out_s1, out_s0, out_sub      result select and subtract control
//     err_illegal, err_clr         sticky illegal-opcode flag and its clear
//   Optional (macro ALU_ISSUE_PERF_EN):
//     perf_issued, perf_stall      issue / stall counters, cleared by err_clr
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_s0,
  output logic             out_s1,
  output logic             out_sub,
  output logic             err_illegal,
  input  logic             err_clr
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  localparam int PW = 2 * WIDTH + 3;

  dec_t          w_dec;
  logic          w_accept;
  logic          w_push;
  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_out_payload;
  logic          r_err_illegal;

  assign w_dec        = alu_decode(in_op);
  assign w_accept     = in_valid && in_ready;
  // Illegal ops complete the handshake but never enter the buffer.
  assign w_push       = in_valid && w_dec.legal;
  assign w_in_payload = {in_a, in_b, w_dec.sel, w_dec.sub};

  alu_skid_buf #(.W(PW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_push),
    .o_ready (in_ready),
    .i_data  (w_in_payload),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_payload)
  );

  assign {out_a, out_b, out_s1, out_s0, out_sub} = w_out_payload;

  // Set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_illegal <= 1'b0;
    else if (w_accept && !w_dec.legal)
      r_err_illegal <= 1'b1;
    else if (err_clr)
      r_err_illegal <= 1'b0;
  end

  assign err_illegal = r_err_illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else if (err_clr) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (out_valid && out_ready)
        r_perf_issued <= r_perf_issued + 32'd1;
      if (out_valid && !out_ready)
        r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
